imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder on the fetch path of the RISC-V core. It accepts fetch addresses from the program-counter side over a valid/ready request channel and returns the 32-bit instruction word after a fixed, parameterised latency over a valid/ready response channel. Responses carry a fault code for misaligned or out-of-range addresses. The block also provides a synchronous program-load write port and a flush input that discards a pending fetch on a redirect.

## Interface
- WIDTH, 32, address width in bits.
- DEPTH, 1024, memory depth in 32-bit words. Any value ≥ 2 is legal; a power of two is not required.
- LATENCY, 2, cycles from request acceptance to the first cycle of response valid. Legal range 1..15.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req_valid  in  1  fetch request valid.
- o_req_ready  out  1  block can accept a request this cycle.
- i_req_address  in  WIDTH  byte address of the fetch.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  consumer accepts the response this cycle.
- o_rsp_instr  out  32  instruction word.
- o_rsp_address  out  WIDTH  address of the request being answered.
- o_rsp_fault  out  2  fault code: 00 = ok, 01 = misaligned, 10 = out of range.
- i_flush  in  1  abort the pending or held fetch.
- i_load_en  in  1  program-load write enable.
- i_load_address  in  WIDTH  byte address of the load write; bits [1:0] are ignored.
- i_load_data  in  32  word to write.

## Operation
- Storage is DEPTH x 32 bits. Reset does not clear it. Word index is address[WIDTH-1:2].
- Load port:
  - When i_load_en = 1 and word index < DEPTH, the word is written at the edge.
  - When the word index ≥ DEPTH, the write is dropped silently.
  - The load port is fully independent of the fetch channel.
- FSM states are IDLE, WAIT and RESP. There is a 4-bit down-counter cnt.
- Request acceptance:
  - A request is accepted in a cycle where i_req_valid = 1 and o_req_ready = 1.
  - o_req_ready = !reset && !i_flush && (state == IDLE || (state == RESP && i_rsp_ready)).
- On accept:
  - The address is latched.
  - If LATENCY = 1, the next state is RESP.
  - Otherwise the next state is WAIT with cnt = LATENCY-1.
- WAIT state:
  - If cnt == 1, the next state is RESP.
  - Otherwise cnt decrements.
- Response capture happens on the edge that enters RESP:
  - o_rsp_instr, o_rsp_address and o_rsp_fault are loaded.
  - Memory is read as it was before that edge, so a load write on the same edge is not visible (read-before-write).
- Fault rules:
  - address[1:0] != 0 gives fault 01. Misaligned takes priority over out-of-range.
  - Otherwise, word index ≥ DEPTH gives fault 10.
  - On any fault, o_rsp_instr = 32'h0000_0013 (NOP).
  - Faulting requests use the same latency as good ones.
- RESP state:
  - o_rsp_valid = 1, and all response outputs are held stable until i_rsp_ready = 1.
  - On the response handshake with no new accept, the next state is IDLE.
  - If a new request is accepted in the same cycle, the FSM proceeds as on accept. This allows back-to-back responses every cycle when LATENCY = 1.
- Flush:
  - i_flush = 1 in WAIT or RESP forces IDLE at the next edge and discards the response.
  - No request is accepted in a flush cycle.
  - Flush in IDLE has no effect.
- Priority: reset > flush > response handshake/accept > counting.

## Timing
- Reset values: state IDLE, o_rsp_valid 0, o_rsp_instr 0, o_rsp_address 0, o_rsp_fault 00, cnt 0.
  - o_req_ready is 0 while reset is high and 1 in the first cycle after reset is released.
- Latency: a request accepted in cycle c gives o_rsp_valid = 1 first in cycle c+LATENCY.
- Throughput:
  - One response per LATENCY+1 cycles when the consumer always accepts and the producer only issues from IDLE.
  - One response per cycle when LATENCY = 1 and requests are overlapped with responses in RESP.
- Reset or flush asserted in cycle k: o_rsp_valid = 0 in cycle k+1, regardless of any in-flight request.
- o_rsp_valid never drops without a handshake, except by reset or flush.

## Test plan
- Load words 0..3 with 0x11111111..0x44444444. Fetch 0x8 with LATENCY = 2 and i_rsp_ready = 1 → o_rsp_valid high exactly 2 cycles after accept, instr 0x33333333, fault 00, address 0x8.
- Fetch 0x6 → instr 0x00000013, fault 01. Fetch 4*DEPTH → instr 0x00000013, fault 10. Both responses arrive after the same latency as a good fetch.
- Hold i_rsp_ready = 0 for 5 cycles in RESP → outputs stable and o_req_ready = 0. Release → handshake, then state IDLE the next cycle.
- LATENCY = 1, continuous requests 0x0, 0x4, 0x8 with i_rsp_ready = 1 → three consecutive valid cycles with 0x11111111, 0x22222222, 0x33333333.
- Pulse i_flush one cycle into WAIT → no response ever appears for that request, and the next request is accepted normally. Assert reset mid-WAIT → all outputs return to their reset values the next cycle.
- A load write to word 2 on the same edge that enters RESP for a fetch of 0x8 → the response returns the old word. A re-fetch of 0x8 returns the new word.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency fetch with valid/ready handshakes,
// fault reporting, a program-load write port and redirect flush.
module imem_responder #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [WIDTH-1:0] i_req_address,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [31:0]      o_rsp_instr,
    output logic [WIDTH-1:0] o_rsp_address,
    output logic [1:0]       o_rsp_fault,
    input  logic             i_flush,
    input  logic             i_load_en,
    input  logic [WIDTH-1:0] i_load_address,
    input  logic [31:0]      i_load_data
);

    localparam int              IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [31:0]      instr_q;
    logic [WIDTH-1:0] rsp_addr_q;
    logic [1:0]       fault_q;

    logic [31:0]      mem_q [DEPTH];

    logic             req_ready;
    logic             accept;
    logic             cap;
    logic [WIDTH-1:0] cap_addr;
    logic [1:0]       cap_fault;
    logic [31:0]      cap_instr;
    logic             ld_ok;
    logic [1:0]       unused_load_lsb;

    // Load port: word index compared at full width so a non-power-of-two DEPTH drops cleanly.
    assign ld_ok           = ({2'b00, i_load_address[WIDTH-1:2]} < DEPTH_W);
    assign unused_load_lsb = i_load_address[1:0];

    always_ff @(posedge clk) begin
        if (i_load_en && ld_ok) begin
            mem_q[i_load_address[IW+1:2]] <= i_load_data;
        end
    end

    // Fault classification of the address being captured; misaligned wins.
    always_comb begin
        cap_fault = 2'b00;
        cap_instr = NOP;
        if (cap_addr[1:0] != 2'b00) begin
            cap_fault = 2'b01;
        end else if ({2'b00, cap_addr[WIDTH-1:2]} >= DEPTH_W) begin
            cap_fault = 2'b10;
        end else begin
            cap_instr = mem_q[cap_addr[IW+1:2]];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        cap       = 1'b0;
        cap_addr  = addr_q;
        req_ready = !reset && !i_flush &&
                    (state_q == IDLE || (state_q == RESP && i_rsp_ready));
        accept    = i_req_valid && req_ready;

        if (i_flush) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else if (accept) begin
            addr_d = i_req_address;
            if (LATENCY == 1) begin
                state_d  = RESP;
                cap      = 1'b1;
                cap_addr = i_req_address;
            end else begin
                state_d = WAIT;
                cnt_d   = 4'(LATENCY - 1);
            end
        end else begin
            case (state_q)
                WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_d = RESP;
                        cap     = 1'b1;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    // Capture reads mem_q with non-blocking semantics, so a same-edge load is not seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            instr_q    <= 32'd0;
            rsp_addr_q <= '0;
            fault_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            if (cap) begin
                instr_q    <= cap_instr;
                rsp_addr_q <= cap_addr;
                fault_q    <= cap_fault;
            end
        end
    end

    assign o_req_ready   = req_ready;
    assign o_rsp_valid   = (state_q == RESP);
    assign o_rsp_instr   = instr_q;
    assign o_rsp_address = rsp_addr_q;
    assign o_rsp_fault   = fault_q;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench: two responders (LATENCY 2 and 1) share loads; driver pushes
// expected responses, a negedge monitor checks data, first-valid cycle and hold stability.
module tb_imem_responder;

    localparam int WIDTH = 32;
    localparam int DEPTH = 1024;
    localparam int LAT0  = 2;
    localparam int LAT1  = 1;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [1:0]  fault;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rv;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        flush;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    logic [1:0]  rready;
    logic [1:0]  rvalid;
    logic [31:0] rinstr [2];
    logic [31:0] raddr  [2];
    logic [1:0]  rfault [2];

    exp_t q0[$];
    exp_t q1[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic [1:0]  pv, phs;
    logic [31:0] hi [2];
    logic [31:0] ha [2];
    logic [1:0]  hf [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LAT0)) dut0 (
        .clk(clk), .reset(rst),
        .i_req_valid(rv[0]), .o_req_ready(rready[0]), .i_req_address(req_addr),
        .o_rsp_valid(rvalid[0]), .i_rsp_ready(rsp_ready),
        .o_rsp_instr(rinstr[0]), .o_rsp_address(raddr[0]), .o_rsp_fault(rfault[0]),
        .i_flush(flush), .i_load_en(ld_en), .i_load_address(ld_addr), .i_load_data(ld_data)
    );

    imem_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LAT1)) dut1 (
        .clk(clk), .reset(rst),
        .i_req_valid(rv[1]), .o_req_ready(rready[1]), .i_req_address(req_addr),
        .o_rsp_valid(rvalid[1]), .i_rsp_ready(rsp_ready),
        .o_rsp_instr(rinstr[1]), .o_rsp_address(raddr[1]), .o_rsp_fault(rfault[1]),
        .i_flush(flush), .i_load_en(ld_en), .i_load_address(ld_addr), .i_load_data(ld_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // A new response starts when valid rises or follows a handshake.
    task automatic mon(input int d);
        exp_t e;
        if (rvalid[d] && (!pv[d] || phs[d])) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp dut%0d: got addr %h want no response", d, raddr[d]);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("rsp_instr dut%0d", d), rinstr[d], e.instr);
                chk($sformatf("rsp_addr dut%0d", d), raddr[d], e.addr);
                chk($sformatf("rsp_fault dut%0d", d), {30'd0, rfault[d]}, {30'd0, e.fault});
                chk($sformatf("rsp_cycle dut%0d", d), cyc, e.cyc);
            end
        end else if (rvalid[d] && pv[d] && !phs[d]) begin
            chk($sformatf("hold_instr dut%0d", d), rinstr[d], hi[d]);
            chk($sformatf("hold_addr dut%0d", d), raddr[d], ha[d]);
            chk($sformatf("hold_fault dut%0d", d), {30'd0, rfault[d]}, {30'd0, hf[d]});
        end
        pv[d]  = rvalid[d];
        phs[d] = rvalid[d] && rsp_ready;
        hi[d]  = rinstr[d];
        ha[d]  = raddr[d];
        hf[d]  = rfault[d];
    endtask

    always @(negedge clk) begin
        if (rst) begin
            pv  = 2'b00;
            phs = 2'b00;
        end else begin
            mon(0);
            mon(1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] dat);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = dat;
        tick();
        ld_en   = 1'b0;
    endtask

    // Leaves rv[d] asserted on return so back-to-back issues are possible.
    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] ei,
                         input logic [1:0] ef, input bit expect_rsp);
        exp_t e;
        bit   ok = 1'b0;
        int   n  = 0;
        req_addr = a;
        rv[d]    = 1'b1;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (rready[d]) ok = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout dut%0d: got no accept want accept of %h", d, a);
        end else if (expect_rsp) begin
            e.instr = ei;
            e.addr  = a;
            e.fault = ef;
            e.cyc   = cyc + ((d == 0) ? LAT0 : LAT1);
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        tick();
    endtask

    task automatic drain(input int d);
        bit done = 1'b0;
        int n    = 0;
        rv[d] = 1'b0;
        while (!done && n < 30) begin
            @(negedge clk);
            if (!rvalid[d] && ((d == 0) ? q0.size() : q1.size()) == 0) done = 1'b1;
            tick();
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout dut%0d: got pending response want none", d);
        end
    endtask

    initial begin
        rst = 1'b1; rv = 2'b00; req_addr = '0; rsp_ready = 1'b1; flush = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        pv = '0; phs = '0;
        tick(); tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_valid", {31'd0, rvalid[d]}, 32'd0);
            chk("reset_ready", {31'd0, rready[d]}, 32'd0);
            chk("reset_instr", rinstr[d], 32'd0);
            chk("reset_addr", raddr[d], 32'd0);
            chk("reset_fault", {30'd0, rfault[d]}, 32'd0);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset0", {31'd0, rready[0]}, 32'd1);
        chk("ready_after_reset1", {31'd0, rready[1]}, 32'd1);
        tick();

        load(32'h0, 32'h1111_1111);
        load(32'h4, 32'h2222_2222);
        load(32'h8, 32'h3333_3333);
        load(32'hF, 32'h4444_4444);
        load(32'hFFC, 32'h0BAD_C0DE);
        load(32'h1000, 32'hDEAD_BEEF);

        issue(0, 32'h8, 32'h3333_3333, 2'b00, 1'b1);      drain(0);
        issue(0, 32'h6, 32'h0000_0013, 2'b01, 1'b1);      drain(0);
        issue(0, 32'h1000, 32'h0000_0013, 2'b10, 1'b1);   drain(0);
        issue(0, 32'hFFC, 32'h0BAD_C0DE, 2'b00, 1'b1);    drain(0);
        issue(0, 32'h1002, 32'h0000_0013, 2'b01, 1'b1);   drain(0);

        // Consumer stalls for 5 RESP cycles.
        rsp_ready = 1'b0;
        issue(0, 32'hC, 32'h4444_4444, 2'b00, 1'b1);
        rv[0] = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            chk("stall_valid", {31'd0, rvalid[0]}, 32'd1);
            chk("stall_ready", {31'd0, rready[0]}, 32'd0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", {31'd0, rready[0]}, 32'd1);
        tick();
        @(negedge clk);
        chk("idle_valid", {31'd0, rvalid[0]}, 32'd0);
        chk("idle_ready", {31'd0, rready[0]}, 32'd1);
        tick();

        // Flush one cycle into WAIT; the flushed request must never respond.
        issue(0, 32'h4, 32'h0, 2'b00, 1'b0);
        rv[0] = 1'b0;
        flush = 1'b1;
        rv[1] = 1'b1;
        @(negedge clk);
        chk("flush_no_accept", {31'd0, rready[1]}, 32'd0);
        tick();
        flush = 1'b0;
        rv[1] = 1'b0;
        @(negedge clk);
        chk("flush_valid", {31'd0, rvalid[0]}, 32'd0);
        tick(); tick(); tick();
        issue(0, 32'h4, 32'h2222_2222, 2'b00, 1'b1);      drain(0);

        // Reset mid-WAIT.
        issue(0, 32'h0, 32'h0, 2'b00, 1'b0);
        rv[0] = 1'b0;
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_wait_valid", {31'd0, rvalid[0]}, 32'd0);
        chk("rst_wait_ready", {31'd0, rready[0]}, 32'd0);
        chk("rst_wait_instr", rinstr[0], 32'd0);
        chk("rst_wait_addr", raddr[0], 32'd0);
        chk("rst_wait_fault", {30'd0, rfault[0]}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", {31'd0, rready[0]}, 32'd1);
        tick(); tick(); tick();

        // LATENCY 1: back-to-back requests overlapped with responses.
        issue(1, 32'h0, 32'h1111_1111, 2'b00, 1'b1);
        issue(1, 32'h4, 32'h2222_2222, 2'b00, 1'b1);
        issue(1, 32'h8, 32'h3333_3333, 2'b00, 1'b1);
        drain(1);

        // Load on the RESP-entry edge is not seen; a re-fetch sees it.
        issue(0, 32'h8, 32'h3333_3333, 2'b00, 1'b1);
        rv[0] = 1'b0;
        load(32'h8, 32'hCAFE_F00D);
        drain(0);
        issue(0, 32'h8, 32'hCAFE_F00D, 2'b00, 1'b1);      drain(0);
        issue(1, 32'h8, 32'hCAFE_F00D, 2'b00, 1'b1);      drain(1);

        chk("sb_empty0", q0.size(), 32'd0);
        chk("sb_empty1", q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
